// File: rtl/rvm_mem_bridge_if.sv
// rvm_mem_bridge_if
//   Bus side of rvm_mem_bridge. It carries a valid/ready request channel and a
//   single-cycle valid response channel.
//   master : the bridge. It drives the request fields and receives the response.
//   slave  : the RAM/peripheral fabric.
//   Signals:
//     bus_req_valid  request valid
//     bus_req_ready  fabric accepts the request
//     bus_req_addr   word-aligned request address
//     bus_req_wdata  write data
//     bus_req_wstrb  byte strobes
//     bus_req_write  1 = write
//     bus_rsp_valid  response valid (one cycle)
//     bus_rsp_rdata  response read data
//     bus_rsp_error  response error
interface rvm_mem_bridge_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_req_write;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_error;

  modport master (
    output bus_req_valid,
    output bus_req_addr,
    output bus_req_wdata,
    output bus_req_wstrb,
    output bus_req_write,
    input  bus_req_ready,
    input  bus_rsp_valid,
    input  bus_rsp_rdata,
    input  bus_rsp_error
  );

  modport slave (
    input  bus_req_valid,
    input  bus_req_addr,
    input  bus_req_wdata,
    input  bus_req_wstrb,
    input  bus_req_write,
    output bus_req_ready,
    output bus_rsp_valid,
    output bus_rsp_rdata,
    output bus_rsp_error
  );
endinterface

// File: rtl/rvm_mem_bridge.sv
// rvm_mem_bridge
//   Converts the rvm_core chip-enable/stall memory port into a valid/ready request
//   and valid response bus. Only one transaction is in flight at a time. The bridge
//   rejects misaligned accesses locally, without generating any bus traffic.
//   Ports:
//     clk, resetn       clock and asynchronous active-low reset
//     core_addr/wdata   core request address and write data
//     core_c_en         a request is present
//     core_b_en         byte enables; 0 = word read, nonzero = write
//     core_rdata/error  result, valid while core_stall is low in DONE; held otherwise
//     core_stall        the core holds its request while this is high
//     bus               rvm_mem_bridge_if.master toward the fabric
//   Build option RVM_MEM_BRIDGE_TIMEOUT_EN: a response timeout of TIMEOUT_CYCLES
//   cycles spent in REQ+RSP. A timeout in RSP leaves an orphan. The next response
//   is dropped, and new requests wait in IDLE until that happens.
module rvm_mem_bridge #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  input  logic                  core_c_en,
  input  logic [3:0]            core_b_en,
  output logic [31:0]           core_rdata,
  output logic                  core_error,
  output logic                  core_stall,
  rvm_mem_bridge_if.master      bus
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        idle_block;
  logic        timeout;

  // Legal write patterns are a byte at any offset, a halfword at an even offset, or
  // a full word at offset 0. A read is always a full word.
  function automatic logic is_aligned(input logic [1:0] a, input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    if (be == 4'b0000) begin
      ok = (a == 2'b00);
    end else if (be == (4'b0001 << a)) begin
      ok = 1'b1;
    end else if (!a[0] && (be == (4'b0011 << a))) begin
      ok = 1'b1;
    end else if ((a == 2'b00) && (be == 4'b1111)) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

`ifdef RVM_MEM_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 orphan_q, orphan_d;

  assign idle_block = orphan_q;
  assign timeout    = ((state_q == StReq) || (state_q == StRsp)) &&
                      ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_comb begin
    cnt_d    = cnt_q;
    orphan_d = orphan_q;
    if ((state_q == StIdle) && (state_d != StIdle)) begin
      cnt_d = '0;
    end else if ((state_q == StReq) || (state_q == StRsp)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
    // The fabric still owes a response for a request that timed out in RSP.
    if ((state_q == StRsp) && timeout && !bus.bus_rsp_valid) begin
      orphan_d = 1'b1;
    end else if (orphan_q && bus.bus_rsp_valid) begin
      orphan_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_W ^ TIMEOUT_CYCLES;
  assign idle_block = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    write_d = write_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (core_c_en && !idle_block) begin
          addr_d  = core_addr[31:2];
          wdata_d = core_wdata;
          wstrb_d = core_b_en;
          write_d = |core_b_en;
          if (is_aligned(core_addr[1:0], core_b_en)) begin
            state_d = StReq;
          end else begin
            state_d = StDone;
            rdata_d = '0;
            error_d = 1'b1;
          end
        end
      end
      StReq: begin
        // An accepted request wins over a timeout in the same cycle.
        if (bus.bus_req_ready) begin
          state_d = StRsp;
        end else if (timeout) begin
          state_d = StDone;
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      StRsp: begin
        if (bus.bus_rsp_valid) begin
          state_d = StDone;
          rdata_d = write_q ? 32'h0 : bus.bus_rsp_rdata;
          error_d = bus.bus_rsp_error;
        end else if (timeout) begin
          state_d = StDone;
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign bus.bus_req_valid = (state_q == StReq);
  assign bus.bus_req_addr  = {addr_q, 2'b00};
  assign bus.bus_req_wdata = wdata_q;
  assign bus.bus_req_wstrb = wstrb_q;
  assign bus.bus_req_write = write_q;

  assign core_rdata = rdata_q;
  assign core_error = error_q;
  // The stall is forced low while resetn is held, even though the state is async-reset.
  assign core_stall = resetn & core_c_en & (state_q != StDone);

endmodule

// File: tb/tb_rvm_mem_bridge.sv
// Directed bench for rvm_mem_bridge. It is instantiated with TIMEOUT_CYCLES = 10.
module tb_rvm_mem_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_c_en;
  logic [3:0]  core_b_en;
  logic [31:0] core_rdata;
  logic        core_error;
  logic        core_stall;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rvm_mem_bridge_if bus_if ();

  rvm_mem_bridge #(
    .TIMEOUT_W      (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_c_en  (core_c_en),
    .core_b_en  (core_b_en),
    .core_rdata (core_rdata),
    .core_error (core_error),
    .core_stall (core_stall),
    .bus        (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Each tick lands 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn                = 1'b0;
    core_addr             = '0;
    core_wdata            = '0;
    core_c_en             = 1'b0;
    core_b_en             = '0;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_rsp_valid  = 1'b0;
    bus_if.bus_rsp_rdata  = '0;
    bus_if.bus_rsp_error  = 1'b0;

    // Reset state
    #3;
    chk("rst_req_valid", 32'(bus_if.bus_req_valid), 32'd0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_error", 32'(core_error), 32'd0);
    core_c_en = 1'b1;
    #1;
    chk("rst_stall", 32'(core_stall), 32'd0);
    core_c_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // 1: read 0x100 at minimum latency
    core_addr = 32'h100; core_b_en = 4'b0000; core_c_en = 1'b1; bus_if.bus_req_ready = 1'b1;
    #1;
    chk("t1_stall_idle", 32'(core_stall), 32'd1);
    chk("t1_valid_idle", 32'(bus_if.bus_req_valid), 32'd0);
    tick();
    chk("t1_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
    chk("t1_req_addr", bus_if.bus_req_addr, 32'h100);
    chk("t1_req_write", 32'(bus_if.bus_req_write), 32'd0);
    chk("t1_req_wstrb", 32'(bus_if.bus_req_wstrb), 32'd0);
    chk("t1_stall_req", 32'(core_stall), 32'd1);
    tick();
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hDEADBEEF; bus_if.bus_rsp_error = 1'b0;
    #1;
    chk("t1_stall_rsp", 32'(core_stall), 32'd1);
    chk("t1_valid_rsp", 32'(bus_if.bus_req_valid), 32'd0);
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    chk("t1_stall_done", 32'(core_stall), 32'd0);
    chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_error", 32'(core_error), 32'd0);
    core_c_en = 1'b0;
    tick();
    chk("t1_rdata_hold", core_rdata, 32'hDEADBEEF);
    chk("t1_stall_idle2", 32'(core_stall), 32'd0);

    // 2a: write 0x204 with b_en 1100 is misaligned; ready held high to expose any traffic
    core_addr = 32'h204; core_b_en = 4'b1100; core_wdata = 32'h11112222; core_c_en = 1'b1;
    bus_if.bus_req_ready = 1'b1;
    #1;
    chk("t2a_stall", 32'(core_stall), 32'd1);
    tick();
    chk("t2a_valid", 32'(bus_if.bus_req_valid), 32'd0);
    chk("t2a_stall_done", 32'(core_stall), 32'd0);
    chk("t2a_error", 32'(core_error), 32'd1);
    chk("t2a_rdata", core_rdata, 32'h0);
    core_c_en = 1'b0;
    tick();
    chk("t2a_valid_after", 32'(bus_if.bus_req_valid), 32'd0);
    bus_if.bus_req_ready = 1'b0;

    // 2b: write 0x206 with b_en 1100 is a legal upper halfword
    core_addr = 32'h206; core_b_en = 4'b1100; core_wdata = 32'hCAFEF00D; core_c_en = 1'b1;
    tick();
    chk("t2b_valid", 32'(bus_if.bus_req_valid), 32'd1);
    chk("t2b_addr", bus_if.bus_req_addr, 32'h204);
    chk("t2b_wstrb", 32'(bus_if.bus_req_wstrb), 32'hC);
    chk("t2b_write", 32'(bus_if.bus_req_write), 32'd1);
    chk("t2b_wdata", bus_if.bus_req_wdata, 32'hCAFEF00D);
    bus_if.bus_req_ready = 1'b1;
    tick();
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h12345678;
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    chk("t2b_rdata_zero", core_rdata, 32'h0);
    chk("t2b_error", 32'(core_error), 32'd0);
    chk("t2b_stall_done", 32'(core_stall), 32'd0);
    core_c_en = 1'b0;
    tick();

    // 2c: misaligned read
    core_addr = 32'h102; core_b_en = 4'b0000; core_c_en = 1'b1;
    tick();
    chk("t2c_error", 32'(core_error), 32'd1);
    chk("t2c_stall", 32'(core_stall), 32'd0);
    core_c_en = 1'b0;
    tick();

    // 3: ready low for 5 REQ cycles, then an error response
    core_addr = 32'h300; core_b_en = 4'b0000; core_c_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_hold", 32'(bus_if.bus_req_valid), 32'd1);
      chk("t3_addr_hold", bus_if.bus_req_addr, 32'h300);
      tick();
    end
    bus_if.bus_req_ready = 1'b1;
    chk("t3_valid_last", 32'(bus_if.bus_req_valid), 32'd1);
    tick();
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_error = 1'b1; bus_if.bus_rsp_rdata = 32'h55;
    tick();
    bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_error = 1'b0;
    chk("t3_error", 32'(core_error), 32'd1);
    chk("t3_rdata", core_rdata, 32'h55);
    core_c_en = 1'b0;
    tick();

`ifdef RVM_MEM_BRIDGE_TIMEOUT_EN
    // 4: timeout after 10 REQ+RSP cycles, then an orphan response is dropped
    core_addr = 32'h600; core_b_en = 4'b0000; core_c_en = 1'b1; bus_if.bus_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_wait", 32'(core_stall), 32'd1);
      tick();
    end
    chk("t4_timeout_stall", 32'(core_stall), 32'd0);
    chk("t4_timeout_error", 32'(core_error), 32'd1);
    chk("t4_timeout_rdata", core_rdata, 32'h0);
    core_addr = 32'h604;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_orphan_stall", 32'(core_stall), 32'd1);
      chk("t4_orphan_no_req", 32'(bus_if.bus_req_valid), 32'd0);
      tick();
    end
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hBADBAD00;
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    chk("t4_idle_after_drop", 32'(bus_if.bus_req_valid), 32'd0);
    tick();
    chk("t4_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
    chk("t4_req_addr", bus_if.bus_req_addr, 32'h604);
    tick();
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h60460460;
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    chk("t4_own_rdata", core_rdata, 32'h60460460);
    chk("t4_own_error", 32'(core_error), 32'd0);
    core_c_en = 1'b0; bus_if.bus_req_ready = 1'b0;
    tick();
`else
    // 4: without the timeout option, REQ and RSP wait indefinitely
    core_addr = 32'h600; core_b_en = 4'b0000; core_c_en = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) tick();
    chk("t4_req_still_valid", 32'(bus_if.bus_req_valid), 32'd1);
    chk("t4_req_still_addr", bus_if.bus_req_addr, 32'h600);
    bus_if.bus_req_ready = 1'b1;
    tick();
    bus_if.bus_req_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t4_rsp_still_stall", 32'(core_stall), 32'd1);
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h600D600D;
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    chk("t4_late_rdata", core_rdata, 32'h600D600D);
    chk("t4_late_error", 32'(core_error), 32'd0);
    core_c_en = 1'b0;
    tick();
`endif

    // 5: reset during RSP, stray response ignored, then a clean read
    core_addr = 32'h400; core_b_en = 4'b0000; core_c_en = 1'b1; bus_if.bus_req_ready = 1'b1;
    tick();
    tick();
    bus_if.bus_req_ready = 1'b0;
    resetn = 1'b0;
    #1;
    chk("t5_valid_rst", 32'(bus_if.bus_req_valid), 32'd0);
    chk("t5_stall_rst", 32'(core_stall), 32'd0);
    chk("t5_rdata_rst", core_rdata, 32'h0);
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'hBAD0BAD0;
    core_c_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    tick();
    chk("t5_rdata_stray", core_rdata, 32'h0);
    chk("t5_valid_after", 32'(bus_if.bus_req_valid), 32'd0);
    chk("t5_stall_after", 32'(core_stall), 32'd0);
    core_addr = 32'h500; core_c_en = 1'b1; bus_if.bus_req_ready = 1'b1;
    #1;
    chk("t5_stall_idle", 32'(core_stall), 32'd1);
    tick();
    chk("t5_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
    chk("t5_req_addr", bus_if.bus_req_addr, 32'h500);
    tick();
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h0A0A0A0A;
    tick();
    bus_if.bus_rsp_valid = 1'b0;
    chk("t5_rdata", core_rdata, 32'h0A0A0A0A);
    chk("t5_stall_done", 32'(core_stall), 32'd0);
    core_c_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
